groestl_subbytes_folded: RTL and testbench



---
 rtl/groestl_pkg.sv | 28 ++
 rtl/groestl_subbytes_folded_sbox.sv | 40 ++++
 rtl/groestl_subbytes_folded.sv | 113 +++++++++++
 tb/tb_groestl_subbytes_folded.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/groestl_pkg.sv
// Shared definitions for the Groestl round datapath: state geometry,
// byte addressing and the folded SubBytes controller states.
package groestl_pkg;

   localparam int GROESTL_COLS_512  = 8;
   localparam int GROESTL_COLS_1024 = 16;

   // NBYTES = 8*COLS ; BEATS = NBYTES/LANES
   function automatic int nbytes(input int cols);
      return 8 * cols;
   endfunction

   function automatic int beats(input int cols, input int lanes);
      return (8 * cols) / lanes;
   endfunction

   function automatic int byte_idx(input int col, input int row);
      return 8 * col + row;
   endfunction

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } sb_state_e;

endpackage

// File: rtl/groestl_subbytes_folded_sbox.sv
// AES S-box cell: multiplicative inverse in GF(2^8) (as x^254, zero maps to
// zero) followed by the AES affine transform.
module AES_Comp_SboxComp (
   input  logic [7:0] i_a,
   output logic [7:0] o_q
);

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   logic [7:0] w_sq;
   logic [7:0] w_inv;

   // x^254 = x^2 * x^4 * ... * x^128
   always_comb begin
      w_sq  = i_a;
      w_inv = 8'h01;
      for (int i = 0; i < 7; i++) begin
         w_sq  = gf_mul(w_sq, w_sq);
         w_inv = gf_mul(w_inv, w_sq);
      end
   end

   assign o_q = w_inv
              ^ {w_inv[6:0], w_inv[7]}
              ^ {w_inv[5:0], w_inv[7:6]}
              ^ {w_inv[4:0], w_inv[7:5]}
              ^ {w_inv[3:0], w_inv[7:4]}
              ^ 8'h63;

endmodule

// File: rtl/groestl_subbytes_folded.sv
// Folded SubBytes for the Groestl state: LANES S-boxes sweep the work
// register in BEATS cycles, optionally with a write-back pipeline stage.
module groestl_subbytes_folded
   import groestl_pkg::*;
#(
   parameter int COLS  = GROESTL_COLS_512,
   parameter int LANES = 8,
   parameter int PIPE  = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [8*8*COLS-1:0]  in_state,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [8*8*COLS-1:0]  out_state,
   output logic                 busy
);

   localparam int NBYTES = nbytes(COLS);
   localparam int BEATS  = beats(COLS, LANES);
   localparam int CW     = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int IW     = $clog2(NBYTES) + 1;
   localparam int SW     = IW + 3;
   localparam int DW     = 8 * NBYTES;
   localparam int LW     = 8 * LANES;

   sb_state_e       r_state;
   logic [CW-1:0]   r_cnt;
   logic [DW-1:0]   r_work;
   logic [LW-1:0]   r_pipe_data;
   logic [CW-1:0]   r_pipe_idx;
   logic            r_pipe_vld;

   logic [SW-1:0]   w_rd_shamt;
   logic [LW-1:0]   w_sb_in;
   logic [LW-1:0]   w_sb_out;
   logic [CW-1:0]   w_wb_idx;
   logic [LW-1:0]   w_wb_data;
   logic            w_wb_en;
   logic [SW-1:0]   w_wb_shamt;
   logic [DW-1:0]   w_work_wb;

   // Lane select: beat cnt covers bytes cnt*LANES .. cnt*LANES+LANES-1
   assign w_rd_shamt = {IW'(r_cnt) * IW'(LANES), 3'b000};
   assign w_sb_in    = LW'(r_work >> w_rd_shamt);

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      AES_Comp_SboxComp u_sbox (
         .i_a (w_sb_in[8*l +: 8]),
         .o_q (w_sb_out[8*l +: 8])
      );
   end

   // With PIPE the write-back trails the S-box read by one cycle
   assign w_wb_idx   = (PIPE != 0) ? r_pipe_idx  : r_cnt;
   assign w_wb_data  = (PIPE != 0) ? r_pipe_data : w_sb_out;
   assign w_wb_en    = (PIPE != 0) ? r_pipe_vld  : (r_state == RUN);
   assign w_wb_shamt = {IW'(w_wb_idx) * IW'(LANES), 3'b000};
   assign w_work_wb  = (r_work & ~(DW'({LW{1'b1}}) << w_wb_shamt))
                     | (DW'(w_wb_data) << w_wb_shamt);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_work      <= '0;
         r_pipe_data <= '0;
         r_pipe_idx  <= '0;
         r_pipe_vld  <= 1'b0;
      end else begin
         r_pipe_vld <= 1'b0;
         if (w_wb_en) r_work <= w_work_wb;
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_work  <= in_state;
                  r_cnt   <= '0;
                  r_state <= RUN;
               end
            end
            RUN: begin
               r_pipe_data <= w_sb_out;
               r_pipe_idx  <= r_cnt;
               r_pipe_vld  <= (PIPE != 0);
               if (r_cnt == CW'(BEATS - 1)) r_state <= (PIPE != 0) ? DRAIN : DONE;
               else                         r_cnt   <= r_cnt + CW'(1);
            end
            DRAIN: r_state <= DONE;
            DONE: begin
               if (out_ready) begin
                  if (in_valid) begin
                     r_work  <= in_state;
                     r_cnt   <= '0;
                     r_state <= RUN;
                  end else begin
                     r_state <= IDLE;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Valid/ready: a transfer happens on any edge where valid and ready are both high.
   assign in_ready  = (r_state == IDLE) || ((r_state == DONE) && out_ready);
   assign out_valid = (r_state == DONE);
   assign busy      = (r_state == RUN) || (r_state == DRAIN);
   assign out_state = r_work;

endmodule

// File: tb/tb_groestl_subbytes_folded.sv
// Bench for groestl_subbytes_folded: four configurations side by side,
// checked each cycle against a transaction-level reference.
module tb_groestl_subbytes_folded;

   localparam int ND = 4;
   localparam int W  = 1024;
   // d0: COLS=8 LANES=8 PIPE=0 | d1: 8,1,1 | d2: 16,128,1 | d3: 16,4,0
   localparam int C_NB  [ND] = '{64, 64, 128, 128};
   localparam int C_LAT [ND] = '{8, 65, 2, 32};
   localparam int C_RND [ND] = '{600, 150, 1000, 300};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_n     [ND];
   logic         in_valid  [ND];
   logic         in_ready  [ND];
   logic         out_valid [ND];
   logic         out_ready [ND];
   logic         busy      [ND];
   logic [W-1:0] in_st     [ND];
   logic [W-1:0] out_st    [ND];
   logic [511:0]  w_o0, w_o1;
   logic [1023:0] w_o2, w_o3;

   groestl_subbytes_folded #(.COLS(8), .LANES(8), .PIPE(0)) u_d0 (
      .clk(clk), .rst_n(rst_n[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .in_state(in_st[0][511:0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
      .out_state(w_o0), .busy(busy[0]));
   groestl_subbytes_folded #(.COLS(8), .LANES(1), .PIPE(1)) u_d1 (
      .clk(clk), .rst_n(rst_n[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .in_state(in_st[1][511:0]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
      .out_state(w_o1), .busy(busy[1]));
   groestl_subbytes_folded #(.COLS(16), .LANES(128), .PIPE(1)) u_d2 (
      .clk(clk), .rst_n(rst_n[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
      .in_state(in_st[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
      .out_state(w_o2), .busy(busy[2]));
   groestl_subbytes_folded #(.COLS(16), .LANES(4), .PIPE(0)) u_d3 (
      .clk(clk), .rst_n(rst_n[3]), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
      .in_state(in_st[3]), .out_valid(out_valid[3]), .out_ready(out_ready[3]),
      .out_state(w_o3), .busy(busy[3]));

   always_comb begin
      out_st[0] = {512'b0, w_o0};
      out_st[1] = {512'b0, w_o1};
      out_st[2] = w_o2;
      out_st[3] = w_o3;
   end

   int n_cmp = 0;
   int n_err = 0;

   function automatic void chk(input string name, input logic [W-1:0] act,
                               input logic [W-1:0] exp);
      int b;
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         b = 0;
         for (int i = W/8 - 1; i >= 0; i--) if (act[8*i +: 8] !== exp[8*i +: 8]) b = i;
         $display("FAIL %s: byte %0d is %h, expected %h (low word %h vs %h)",
                  name, b, act[8*b +: 8], exp[8*b +: 8], act[63:0], exp[63:0]);
      end
   endfunction

   // ---------------- reference S-box from the field definition -------------
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [14:0] p;
      p = '0;
      for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
      for (int j = 14; j >= 8; j--) if (p[j]) p = p ^ (15'h11b << (j - 8));
      return p[7:0];
   endfunction

   function automatic logic [7:0] ref_sbox(input logic [7:0] x);
      logic [7:0] inv, s, c;
      inv = 8'h00;
      c   = 8'h63;
      for (int y = 1; y < 256; y++) if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
         s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      return s;
   endfunction

   logic [7:0] sb_tab [256];

   function automatic logic [W-1:0] ref_state(input int d, input logic [W-1:0] st);
      logic [W-1:0] r;
      r = '0;
      for (int k = 0; k < C_NB[d]; k++) r[8*k +: 8] = sb_tab[st[8*k +: 8]];
      return r;
   endfunction

   // ---------------- transaction model + scoreboard ------------------------
   int           cyc = 0;
   bit           job      [ND];
   int           t_acc    [ND];
   int           acc_last [ND];
   int           acc_prev [ND];
   int           n_acc    [ND];
   int           n_hs     [ND];
   int           n_sent   [ND];
   bit           s_acc    [ND];
   bit           s_hs     [ND];
   logic [W-1:0] s_st     [ND];
   logic [W-1:0] exp_q    [ND][$];
   bit           rnd_rdy  [ND];

   always @(posedge clk) begin
      cyc++;
      for (int d = 0; d < ND; d++) begin
         if (rst_n[d]) begin
            if (s_hs[d]) begin
               if (exp_q[d].size() > 0) void'(exp_q[d].pop_front());
               job[d] = 1'b0;
               n_hs[d]++;
            end
            if (s_acc[d]) begin
               exp_q[d].push_back(ref_state(d, s_st[d]));
               job[d]      = 1'b1;
               t_acc[d]    = cyc;
               acc_prev[d] = acc_last[d];
               acc_last[d] = cyc;
               n_acc[d]++;
            end
         end
      end
   end

   always @(negedge clk) begin
      for (int d = 0; d < ND; d++) begin
         bit e_ov, e_ir;
         if (!rst_n[d]) begin
            job[d] = 1'b0;
            exp_q[d].delete();
            s_acc[d] = 1'b0;
            s_hs[d]  = 1'b0;
            chk($sformatf("d%0d_rst_out_valid", d), W'(out_valid[d]), W'(0));
            chk($sformatf("d%0d_rst_in_ready", d), W'(in_ready[d]), W'(1));
            chk($sformatf("d%0d_rst_busy", d), W'(busy[d]), W'(0));
            chk($sformatf("d%0d_rst_out_state", d), out_st[d], '0);
         end else begin
            e_ov = job[d] && (cyc >= t_acc[d] + C_LAT[d]);
            e_ir = !job[d] || (e_ov && out_ready[d]);
            chk($sformatf("d%0d_out_valid", d), W'(out_valid[d]), W'(e_ov));
            chk($sformatf("d%0d_in_ready", d), W'(in_ready[d]), W'(e_ir));
            chk($sformatf("d%0d_busy", d), W'(busy[d]), W'(job[d] && !e_ov));
            if (e_ov) begin
               if (exp_q[d].size() > 0)
                  chk($sformatf("d%0d_out_state", d), out_st[d], exp_q[d][0]);
               else
                  chk($sformatf("d%0d_queue_empty", d), W'(0), W'(1));
            end
            s_acc[d] = in_valid[d] && e_ir;
            s_hs[d]  = e_ov && out_ready[d];
            s_st[d]  = in_st[d];
         end
      end
   end

   always @(posedge clk) begin
      #1;
      for (int d = 0; d < ND; d++)
         if (rnd_rdy[d]) out_ready[d] = ($urandom_range(0, 3) != 0);
   end

   // ---------------- driver tasks ------------------------------------------
   function automatic logic [W-1:0] rnd_state();
      logic [W-1:0] r;
      for (int i = 0; i < W/32; i++) r[32*i +: 32] = $urandom;
      return r;
   endfunction

   task automatic send_job(input int d, input logic [W-1:0] st);
      int k;
      in_st[d]    = st;
      in_valid[d] = 1'b1;
      n_sent[d]++;
      k = 0;
      @(negedge clk);
      while (!in_ready[d] && k < 2000) begin
         @(negedge clk);
         k++;
      end
      if (k >= 2000) chk($sformatf("d%0d_accept_timeout", d), W'(0), W'(1));
      @(posedge clk);
      #1;
      in_valid[d] = 1'b0;
      in_st[d]    = rnd_state();
   endtask

   task automatic wait_valid(input int d);
      int k;
      k = 0;
      @(negedge clk);
      while (!out_valid[d] && k < 2000) begin
         @(negedge clk);
         k++;
      end
      if (k >= 2000) chk($sformatf("d%0d_valid_timeout", d), W'(0), W'(1));
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic rnd_jobs(input int d, input int n);
      rnd_rdy[d] = 1'b1;
      for (int i = 0; i < n; i++) begin
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
         send_job(d, rnd_state());
      end
      rnd_rdy[d]   = 1'b0;
      out_ready[d] = 1'b1;
   endtask

   // ---------------- directed + random sequence ----------------------------
   initial begin
      logic [W-1:0] st, snap;
      int hs0, k;
      for (int x = 0; x < 256; x++) sb_tab[x] = ref_sbox(8'(x));
      for (int d = 0; d < ND; d++) begin
         rst_n[d] = 1'b0; in_valid[d] = 1'b0; out_ready[d] = 1'b0; in_st[d] = '0;
      end
      chk("model_s00", W'(sb_tab[8'h00]), W'(8'h63));
      chk("model_s01", W'(sb_tab[8'h01]), W'(8'h7c));
      chk("model_s3f", W'(sb_tab[8'h3f]), W'(8'h75));
      chk("model_sff", W'(sb_tab[8'hff]), W'(8'h16));
      chk("model_s53", W'(sb_tab[8'h53]), W'(8'hed));
      repeat (2) @(posedge clk);
      #2;
      for (int d = 0; d < ND; d++) rst_n[d] = 1'b1;
      idle(1);

      // all-zero state, 8 beats of 8 lanes
      out_ready[0] = 1'b1;
      send_job(0, '0);
      wait_valid(0);
      chk("t1_latency", W'(cyc - acc_last[0]), W'(8));
      chk("t1_all_63", out_st[0], W'({64{8'h63}}));
      idle(2);

      // byte k = k through a single lane with pipe stage
      st = '0;
      for (int i = 0; i < 64; i++) st[8*i +: 8] = 8'(i);
      out_ready[1] = 1'b1;
      send_job(1, st);
      wait_valid(1);
      chk("t2_latency", W'(cyc - acc_last[1]), W'(65));
      chk("t2_byte00", W'(out_st[1][7:0]), W'(8'h63));
      chk("t2_byte01", W'(out_st[1][15:8]), W'(8'h7c));
      chk("t2_byte3f", W'(out_st[1][511:504]), W'(8'h75));
      idle(2);

      // full-width single beat, back-to-back jobs
      out_ready[2] = 1'b1;
      send_job(2, {128{8'hff}});
      send_job(2, {128{8'h53}});
      chk("t3_b2b_spacing", W'(acc_last[2] - acc_prev[2]), W'(3));
      wait_valid(2);
      chk("t3_all_ed", out_st[2], {128{8'hed}});
      idle(2);

      // backpressure hold
      out_ready[0] = 1'b0;
      send_job(0, rnd_state());
      wait_valid(0);
      snap = out_st[0];
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("t4_hold_valid", W'(out_valid[0]), W'(1));
         chk("t4_hold_state", out_st[0], snap);
         chk("t4_hold_in_ready", W'(in_ready[0]), W'(0));
      end
      @(posedge clk);
      #1;
      out_ready[0] = 1'b1;
      hs0 = n_hs[0];
      @(negedge clk);
      @(posedge clk);
      @(negedge clk);
      chk("t4_after_valid", W'(out_valid[0]), W'(0));
      chk("t4_after_in_ready", W'(in_ready[0]), W'(1));
      chk("t4_one_handshake", W'(n_hs[0] - hs0), W'(1));
      idle(1);

      // reset in the middle of a job
      send_job(0, rnd_state());
      repeat (3) @(posedge clk);
      #2;
      rst_n[0] = 1'b0;
      #1;
      chk("t5_rst_valid", W'(out_valid[0]), W'(0));
      chk("t5_rst_busy", W'(busy[0]), W'(0));
      chk("t5_rst_in_ready", W'(in_ready[0]), W'(1));
      chk("t5_rst_state", out_st[0], '0);
      @(posedge clk);
      #2;
      rst_n[0] = 1'b1;
      #1;
      chk("t5_rel_in_ready", W'(in_ready[0]), W'(1));
      idle(1);
      st = rnd_state();
      send_job(0, st);
      wait_valid(0);
      chk("t5_fresh_result", out_st[0], ref_state(0, st));
      idle(2);

      // randomized traffic on all four configurations concurrently
      fork
         rnd_jobs(0, C_RND[0]);
         rnd_jobs(1, C_RND[1]);
         rnd_jobs(2, C_RND[2]);
         rnd_jobs(3, C_RND[3]);
      join
      k = 0;
      while ((job[0] || job[1] || job[2] || job[3]) && k < 2000) begin
         @(posedge clk);
         k++;
      end
      if (k >= 2000) chk("drain_timeout", W'(0), W'(1));
      idle(2);
      for (int d = 0; d < ND; d++) begin
         chk($sformatf("d%0d_accepts", d), W'(n_acc[d]), W'(n_sent[d]));
         chk($sformatf("d%0d_handshakes", d), W'(n_hs[d]), W'(n_acc[d] - ((d == 0) ? 1 : 0)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
